rf_writeback: RTL

- Writer side of the integer register-file write port; sole driver of the file's wen/rd_idx/rd_wdata.
- Merges two result sources onto the single write port:
  - in-order pipeline retire path: priority, no backpressure;
  - long-latency unit path (load/mul-div): valid/ready handshake, buffered in a small FIFO.
- Provides a pending-write query for hazard detection and a starvation stall request to the pipeline.

---
 rtl/rf_writeback.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rf_writeback.sv
// Register-file write-port merger: pipeline retire path (priority) plus a buffered long-latency path.
// Optional macro RF_WB_STATS_EN adds the stall_cycles and lu_drops statistics ports.
module rf_writeback #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic [4:0]      q_idx,
    output logic            q_pending,
    output logic            stall_o,
    output logic            wen,
    output logic [4:0]      rd_idx,
    output logic [XLEN-1:0] rd_wdata
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [15:0]     lu_drops
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int EW = XLEN + 5;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW:0]     wrPtr_q;
    logic [AW:0]     rdPtr_q;
    logic [AW:0]     fifoUsed;
    logic [AW-1:0]   slotOff;
    logic [CW-1:0]   starveCnt_q;
    logic [CW-1:0]   starveCnt_d;
    logic            stall_q;
    logic            stall_d;
    logic            wen_q;
    logic [4:0]      rdIdx_q;
    logic [XLEN-1:0] rdWdata_q;
    logic            fifoEmpty;
    logic            fifoFull;
    logic            push;
    logic            pipeReq;
    logic            grantFifo;
    logic            grantPipe;
    logic [EW-1:0]   headEntry;

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign fifoUsed  = wrPtr_q - rdPtr_q;
    assign headEntry = mem_q[rdPtr_q[AW-1:0]];

    assign lu_ready  = !fifoFull;
    assign push      = lu_valid && !fifoFull && (lu_rd != 5'd0);
    assign pipeReq   = pipe_valid && (pipe_rd != 5'd0) && !stall_q;

    // While stalled pipeReq is forced low, so the FIFO head wins whenever the pipe is quiet.
    assign grantPipe = pipeReq;
    assign grantFifo = !fifoEmpty && !pipeReq;

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (fifoEmpty || grantFifo) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != CW'(STARVE_MAX)) begin
            starveCnt_d = starveCnt_q + CW'(1);
        end
        stall_d = stall_q;
        if (stall_q && grantFifo) begin
            stall_d = 1'b0;
        end else if (starveCnt_d == CW'(STARVE_MAX)) begin
            stall_d = 1'b1;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        q_pending = 1'b0;
        slotOff   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slotOff = AW'(k) - rdPtr_q[AW-1:0];
            if (({1'b0, slotOff} < fifoUsed) && (mem_q[k][EW-1:XLEN] == q_idx) && (q_idx != 5'd0)) begin
                q_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            starveCnt_q <= '0;
            stall_q     <= 1'b0;
            wen_q       <= 1'b0;
            rdIdx_q     <= '0;
            rdWdata_q   <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + (AW+1)'(1);
            end
            if (grantFifo) begin
                rdPtr_q <= rdPtr_q + (AW+1)'(1);
            end
            starveCnt_q <= starveCnt_d;
            stall_q     <= stall_d;
            wen_q       <= grantFifo || grantPipe;
            if (grantPipe) begin
                rdIdx_q   <= pipe_rd;
                rdWdata_q <= pipe_data;
            end else if (grantFifo) begin
                rdIdx_q   <= headEntry[EW-1:XLEN];
                rdWdata_q <= headEntry[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= {lu_rd, lu_data};
        end
    end

    assign stall_o  = stall_q;
    assign wen      = wen_q;
    assign rd_idx   = rdIdx_q;
    assign rd_wdata = rdWdata_q;

`ifdef RF_WB_STATS_EN
    logic [31:0] stallCycles_q;
    logic [15:0] luDrops_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stallCycles_q <= '0;
            luDrops_q     <= '0;
        end else begin
            if (stall_q) begin
                stallCycles_q <= stallCycles_q + 32'd1;
            end
            if (lu_valid && !fifoFull && (lu_rd == 5'd0) && (luDrops_q != 16'hFFFF)) begin
                luDrops_q <= luDrops_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stallCycles_q;
    assign lu_drops     = luDrops_q;
`endif

endmodule
